// File: rtl/ts_pkg.sv
// Shared widths, types and helpers for the timestamper client arbiter.
package ts_pkg;

   localparam int ID_W_DEF  = 4;
   localparam int TS_W_DEF  = 64;
   localparam int N_CLI_MAX = 16;

   typedef logic [ID_W_DEF-1:0]           ts_id_t;
   typedef logic [TS_W_DEF-1:0]           ts_t;
   typedef logic [$clog2(N_CLI_MAX)-1:0]  client_idx_t;

   typedef struct packed {
      ts_id_t id;
      ts_t    start_ts;
      ts_t    end_ts;
      ts_t    delta;
   } ts_rec_t;

   // Index width that stays legal for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the
// granted requester only when the grant is consumed.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          fire,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] r_ptr;
   logic          w_found;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers a latch.
   always_comb begin : p_pick
      int k;
      k         = 0;
      w_found   = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         k = (int'(r_ptr) + i) % N;
         if (!w_found && req[k]) begin
            w_found   = 1'b1;
            grant_idx = IW'(k);
         end
      end
      grant = w_found ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= '0;
      else if (fire)
         r_ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/ts_client_arbiter.sv
// Shares one event timestamper between N_CLI clients: allocates IDs on start,
// checks ownership on end, and routes records back to the owning client.
module ts_client_arbiter
   import ts_pkg::*;
#(
   parameter int N_CLI = 4,
   parameter int ID_W  = ID_W_DEF,
   parameter int TS_W  = TS_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CLI-1:0]      cli_start_valid,
   output logic [N_CLI-1:0]      cli_start_ready,
   output logic [ID_W-1:0]       cli_start_id,
   input  logic [N_CLI-1:0]      cli_end_valid,
   output logic [N_CLI-1:0]      cli_end_ready,
   input  logic [N_CLI*ID_W-1:0] cli_end_id,
   output logic [N_CLI-1:0]      cli_rsp_valid,
   input  logic [N_CLI-1:0]      cli_rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [TS_W-1:0]       rsp_start_ts,
   output logic [TS_W-1:0]       rsp_end_ts,
   output logic [TS_W-1:0]       rsp_delta,
   output logic                  ts_start_valid,
   input  logic                  ts_start_ready,
   output logic [ID_W-1:0]       ts_start_id,
   output logic                  ts_end_valid,
   input  logic                  ts_end_ready,
   output logic [ID_W-1:0]       ts_end_id,
   input  logic                  ts_out_valid,
   output logic                  ts_out_ready,
   input  logic [ID_W-1:0]       ts_out_id,
   input  logic [TS_W-1:0]       ts_out_start_ts,
   input  logic [TS_W-1:0]       ts_out_end_ts,
   input  logic [TS_W-1:0]       ts_out_delta,
   output logic                  err_end,
   output logic [ID_W:0]         busy_cnt
);

   localparam int N_ID = 2**ID_W;
   localparam int CIW  = idx_w(N_CLI);

   logic [N_ID-1:0] r_busy;
   logic [N_ID-1:0] r_ended;
   logic [CIW-1:0]  r_owner [N_ID];
   logic [ID_W:0]   r_busy_cnt;
   logic            r_err_end;

   logic            w_free_avail;
   logic [ID_W-1:0] w_alloc_id;
   logic [N_CLI-1:0] w_start_req, w_start_grant;
   logic [CIW-1:0]  w_start_idx;
   logic            w_start_fire;

   logic [N_CLI-1:0] w_end_req, w_end_grant, w_end_legal;
   logic [CIW-1:0]  w_end_idx;
   logic [ID_W-1:0] w_end_sel_id;
   logic            w_end_any, w_sel_legal, w_end_fire, w_end_drop;

   logic [CIW-1:0]  w_rsp_owner;
   logic            w_rsp_fire;

   // ---------------- start path ----------------
   // Descending scan: the last hit is the lowest free index.
   always_comb begin
      w_alloc_id = '0;
      for (int i = N_ID-1; i >= 0; i--)
         if (!r_busy[i]) w_alloc_id = ID_W'(i);
   end

   assign w_free_avail    = ~&r_busy;
   assign w_start_req     = rst ? '0 : cli_start_valid;
   assign ts_start_valid  = w_free_avail && |w_start_req;
   assign ts_start_id     = w_alloc_id;
   assign w_start_fire    = ts_start_valid && ts_start_ready;
   assign cli_start_ready = (ts_start_ready && w_free_avail) ? w_start_grant : '0;
   assign cli_start_id    = w_alloc_id;

   rr_arbiter #(.N(N_CLI)) u_start_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (w_start_req),
      .fire      (w_start_fire),
      .grant     (w_start_grant),
      .grant_idx (w_start_idx)
   );

   // ---------------- end path ----------------
   for (genvar c = 0; c < N_CLI; c++) begin : g_end
      logic [ID_W-1:0] w_id;
      assign w_id           = cli_end_id[c*ID_W +: ID_W];
      assign w_end_legal[c] = r_busy[w_id] && !r_ended[w_id] && (r_owner[w_id] == CIW'(c));
   end

   assign w_end_req    = rst ? '0 : cli_end_valid;
   assign w_end_any    = |w_end_req;
   assign w_sel_legal  = w_end_legal[w_end_idx];
   assign w_end_sel_id = cli_end_id[w_end_idx*ID_W +: ID_W];
   assign ts_end_valid = w_end_any && w_sel_legal;
   assign ts_end_id    = w_end_sel_id;
   assign w_end_fire   = ts_end_valid && ts_end_ready;
   // Illegal requests are consumed immediately so a faulty client cannot stall the port.
   assign w_end_drop   = w_end_any && !w_sel_legal;
   assign cli_end_ready = (w_sel_legal && !ts_end_ready) ? '0 : w_end_grant;

   rr_arbiter #(.N(N_CLI)) u_end_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (w_end_req),
      .fire      (w_end_fire || w_end_drop),
      .grant     (w_end_grant),
      .grant_idx (w_end_idx)
   );

   // ---------------- response path ----------------
   assign w_rsp_owner = r_owner[ts_out_id];

   always_comb begin
      cli_rsp_valid = '0;
      ts_out_ready  = 1'b0;
      for (int c = 0; c < N_CLI; c++) begin
         if (w_rsp_owner == CIW'(c)) begin
            cli_rsp_valid[c] = ts_out_valid && !rst;
            ts_out_ready     = cli_rsp_ready[c] && !rst;
         end
      end
   end

   assign w_rsp_fire   = ts_out_valid && ts_out_ready;
   assign rsp_id       = ts_out_id;
   assign rsp_start_ts = ts_out_start_ts;
   assign rsp_end_ts   = ts_out_end_ts;
   assign rsp_delta    = ts_out_delta;

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_ended    <= '0;
         r_busy_cnt <= '0;
         r_err_end  <= 1'b0;
      end else begin
         r_err_end <= w_end_drop;
         if (w_rsp_fire) begin
            r_busy[ts_out_id]  <= 1'b0;
            r_ended[ts_out_id] <= 1'b0;
         end
         if (w_start_fire) begin
            r_busy[w_alloc_id]  <= 1'b1;
            r_ended[w_alloc_id] <= 1'b0;
         end
         if (w_end_fire)
            r_ended[w_end_sel_id] <= 1'b1;
         case ({w_start_fire, w_rsp_fire})
            2'b10:   r_busy_cnt <= r_busy_cnt + 1'b1;
            2'b01:   r_busy_cnt <= r_busy_cnt - 1'b1;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   // NOTE: the owner table is left out of reset on purpose; an entry is only
   // read while its busy bit is set, and busy is always written with it.
   always_ff @(posedge clk) begin
      if (w_start_fire)
         r_owner[w_alloc_id] <= w_start_idx;
   end

   assign err_end  = r_err_end;
   assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_ts_client_arbiter.sv
// Directed bench for ts_client_arbiter; the bench itself plays the timestamper.
module tb_ts_client_arbiter;

   localparam int N_CLI = 4;
   localparam int ID_W  = 4;
   localparam int TS_W  = 64;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CLI-1:0]      cli_start_valid, cli_start_ready;
   logic [ID_W-1:0]       cli_start_id;
   logic [N_CLI-1:0]      cli_end_valid, cli_end_ready;
   logic [N_CLI*ID_W-1:0] cli_end_id;
   logic [N_CLI-1:0]      cli_rsp_valid, cli_rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [TS_W-1:0]       rsp_start_ts, rsp_end_ts, rsp_delta;
   logic                  ts_start_valid, ts_start_ready;
   logic [ID_W-1:0]       ts_start_id;
   logic                  ts_end_valid, ts_end_ready;
   logic [ID_W-1:0]       ts_end_id;
   logic                  ts_out_valid, ts_out_ready;
   logic [ID_W-1:0]       ts_out_id;
   logic [TS_W-1:0]       ts_out_start_ts, ts_out_end_ts, ts_out_delta;
   logic                  err_end;
   logic [ID_W:0]         busy_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ts_client_arbiter #(.N_CLI(N_CLI), .ID_W(ID_W), .TS_W(TS_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .cli_start_valid (cli_start_valid),
      .cli_start_ready (cli_start_ready),
      .cli_start_id    (cli_start_id),
      .cli_end_valid   (cli_end_valid),
      .cli_end_ready   (cli_end_ready),
      .cli_end_id      (cli_end_id),
      .cli_rsp_valid   (cli_rsp_valid),
      .cli_rsp_ready   (cli_rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_start_ts    (rsp_start_ts),
      .rsp_end_ts      (rsp_end_ts),
      .rsp_delta       (rsp_delta),
      .ts_start_valid  (ts_start_valid),
      .ts_start_ready  (ts_start_ready),
      .ts_start_id     (ts_start_id),
      .ts_end_valid    (ts_end_valid),
      .ts_end_ready    (ts_end_ready),
      .ts_end_id       (ts_end_id),
      .ts_out_valid    (ts_out_valid),
      .ts_out_ready    (ts_out_ready),
      .ts_out_id       (ts_out_id),
      .ts_out_start_ts (ts_out_start_ts),
      .ts_out_end_ts   (ts_out_end_ts),
      .ts_out_delta    (ts_out_delta),
      .err_end         (err_end),
      .busy_cnt        (busy_cnt)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_grant;

      rst = 1'b1;
      cli_start_valid = '0; cli_end_valid = '0; cli_end_id = '0; cli_rsp_ready = '0;
      ts_start_ready = 1'b1; ts_end_ready = 1'b1;
      ts_out_valid = 1'b0; ts_out_id = '0;
      ts_out_start_ts = '0; ts_out_end_ts = '0; ts_out_delta = '0;

      // reset state
      repeat (3) step();
      #1;
      check("rst_busy_cnt",   busy_cnt, 0);
      check("rst_ts_start_v", ts_start_valid, 0);
      check("rst_start_rdy",  cli_start_ready, 0);
      check("rst_err_end",    err_end, 0);
      check("rst_rsp_valid",  cli_rsp_valid, 0);
      check("rst_ts_out_rdy", ts_out_ready, 0);
      rst = 1'b0;
      step();

      // client 0 then client 2
      cli_start_valid = 4'b0001; #1;
      check("c0_start_rdy", cli_start_ready, 4'b0001);
      check("c0_start_id",  cli_start_id, 0);
      check("c0_ts_valid",  ts_start_valid, 1);
      check("c0_ts_id",     ts_start_id, 0);
      step();
      cli_start_valid = 4'b0100; #1;
      check("c2_start_rdy", cli_start_ready, 4'b0100);
      check("c2_start_id",  cli_start_id, 1);
      check("busy_cnt_1",   busy_cnt, 1);
      step();
      cli_start_valid = '0; #1;
      check("busy_cnt_2", busy_cnt, 2);

      // fresh reset for the rotation test
      rst = 1'b1;
      step();
      rst = 1'b0; #1;
      check("rerst_busy_cnt", busy_cnt, 0);

      // timestamper not ready: request visible, nothing accepted
      ts_start_ready = 1'b0;
      cli_start_valid = 4'b0001; #1;
      check("bp_ts_valid",  ts_start_valid, 1);
      check("bp_start_rdy", cli_start_ready, 0);
      step();
      check("bp_busy_cnt", busy_cnt, 0);
      ts_start_ready = 1'b1;

      // all clients request: grants rotate, IDs ascend, pool fills
      cli_start_valid = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         #1;
         exp_grant = 4'b0001 << (k % 4);
         check($sformatf("rot_rdy_%0d", k), cli_start_ready, exp_grant);
         check($sformatf("rot_id_%0d", k),  cli_start_id, k);
         step();
         if (k == 7) check("busy_cnt_8", busy_cnt, 8);
      end
      #1;
      check("full_start_rdy", cli_start_ready, 0);
      check("full_ts_valid",  ts_start_valid, 0);
      check("full_busy_cnt",  busy_cnt, 16);
      cli_start_valid = '0;

      // client 1 ends ID 4 (owned by client 0): dropped with error
      cli_end_valid = 4'b0010; cli_end_id = 16'h0040; #1;
      check("bad_end_rdy",   cli_end_ready, 4'b0010);
      check("bad_end_ts_v",  ts_end_valid, 0);
      step();
      cli_end_valid = '0; #1;
      check("bad_end_err",   err_end, 1);
      step();
      check("err_one_cycle", err_end, 0);

      // client 1 ends its own ID 5, then again (already ended)
      cli_end_valid = 4'b0010; cli_end_id = 16'h0050; #1;
      check("end5_ts_v",  ts_end_valid, 1);
      check("end5_ts_id", ts_end_id, 5);
      check("end5_rdy",   cli_end_ready, 4'b0010);
      step();
      check("end5_no_err",  err_end, 0);
      check("reend5_ts_v",  ts_end_valid, 0);
      check("reend5_rdy",   cli_end_ready, 4'b0010);
      step();
      cli_end_valid = '0; #1;
      check("reend5_err", err_end, 1);

      // client 2 ends its ID 6
      cli_end_valid = 4'b0100; cli_end_id = 16'h0600; #1;
      check("end6_ts_v",  ts_end_valid, 1);
      check("end6_ts_id", ts_end_id, 6);
      step();
      cli_end_valid = '0;

      // record for ID 6 stalled by client 2 for five cycles
      ts_out_valid = 1'b1; ts_out_id = 4'd6;
      ts_out_start_ts = 64'd100; ts_out_end_ts = 64'd137; ts_out_delta = 64'd37;
      cli_rsp_ready = '0; cli_start_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("stall_rsp_v_%0d", k),  cli_rsp_valid, 4'b0100);
         check($sformatf("stall_out_r_%0d", k),  ts_out_ready, 0);
         check($sformatf("stall_delta_%0d", k),  rsp_delta, 37);
         check($sformatf("stall_id_%0d", k),     rsp_id, 6);
         check($sformatf("stall_start_%0d", k),  rsp_start_ts, 100);
         check($sformatf("stall_srdy_%0d", k),   cli_start_ready, 0);
         step();
      end
      cli_rsp_ready = 4'b0100; #1;
      check("rsp6_out_rdy",    ts_out_ready, 1);
      check("rsp6_same_cyc_s", cli_start_ready, 0);
      step();
      ts_out_valid = 1'b0; cli_rsp_ready = '0; #1;
      check("rsp6_busy_cnt", busy_cnt, 15);
      check("realloc6_rdy",  cli_start_ready, 4'b0001);
      check("realloc6_id",   cli_start_id, 6);
      step();
      cli_start_valid = '0; #1;
      check("refill_cnt", busy_cnt, 16);

      // free ID 5 (client 1)
      ts_out_valid = 1'b1; ts_out_id = 4'd5; cli_rsp_ready = 4'b0010; #1;
      check("rsp5_valid",   cli_rsp_valid, 4'b0010);
      check("rsp5_out_rdy", ts_out_ready, 1);
      step();

      // response frees ID 2 while a start fires: start takes 5
      ts_out_id = 4'd2; cli_rsp_ready = 4'b0100; cli_start_valid = 4'b1000; #1;
      check("sim_busy_before", busy_cnt, 15);
      check("sim_rsp_valid",   cli_rsp_valid, 4'b0100);
      check("sim_start_rdy",   cli_start_ready, 4'b1000);
      check("sim_start_id",    cli_start_id, 5);
      step();
      ts_out_valid = 1'b0; cli_rsp_ready = '0; cli_start_valid = 4'b0001; #1;
      check("sim_busy_after",  busy_cnt, 15);
      check("id2_start_rdy",   cli_start_ready, 4'b0001);
      check("id2_start_id",    cli_start_id, 2);
      step();
      cli_start_valid = '0; #1;
      check("final_full_cnt", busy_cnt, 16);

      // mid-operation reset discards everything
      rst = 1'b1;
      step();
      check("midrst_busy_cnt", busy_cnt, 0);
      check("midrst_err_end",  err_end, 0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
